// File: rtl/alu_unit.sv
// 16-bit registered ALU: operand A/B source muxes, logic/add/sub/compare ops,
// result and signed-overflow flag registered for write-back.
module alu_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] mary,
  input  logic [WIDTH-1:0] sp,
  input  logic [WIDTH-1:0] shelley,
  input  logic [WIDTH-1:0] zext_imm,
  input  logic [WIDTH-1:0] sext_imm,
  input  logic [WIDTH-1:0] sext_ls_imm,
  input  logic             SrcA,
  input  logic [1:0]       SrcB,
  input  logic [2:0]       AluOp,
  output logic [WIDTH-1:0] out,
  output logic             Overflow
);

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_SLT   = 3'b100,
    OP_SGT   = 3'b101,
    OP_SEQ   = 3'b110,
    OP_PASSB = 3'b111
  } alu_op_e;

  localparam logic [WIDTH-2:0] ZPAD = '0;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic [WIDTH-1:0] r_out;
  logic             r_ovf;

  always_comb begin
    w_a = SrcA ? sp : mary;
    unique case (SrcB)
      2'b00:   w_b = shelley;
      2'b01:   w_b = zext_imm;
      2'b10:   w_b = sext_imm;
      default: w_b = sext_ls_imm;
    endcase
  end

  assign w_sum  = w_a + w_b;
  assign w_diff = w_a - w_b;

  // Compares use the native signed relation, so they stay correct even when
  // A-B would overflow.
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    unique case (alu_op_e'(AluOp))
      OP_AND:   w_res = w_a & w_b;
      OP_OR:    w_res = w_a | w_b;
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ovf = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_SLT:   w_res = {ZPAD, ($signed(w_a) < $signed(w_b))};
      OP_SGT:   w_res = {ZPAD, ($signed(w_a) > $signed(w_b))};
      OP_SEQ:   w_res = {ZPAD, (w_a == w_b)};
      default:  w_res = w_b;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_out <= w_res;
      r_ovf <= w_ovf;
    end
  end

  assign out      = r_out;
  assign Overflow = r_ovf;

endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit: expected results queued at drive time,
// popped and checked one cycle later.
module tb_alu_unit;

  localparam logic [2:0] AND_ = 3'b000, OR_ = 3'b001, ADD_ = 3'b010, SUB_ = 3'b011,
                         SLT_ = 3'b100, SGT_ = 3'b101, SEQ_ = 3'b110, PASSB_ = 3'b111;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] mary, sp, shelley, zext_imm, sext_imm, sext_ls_imm;
  logic        SrcA;
  logic [1:0]  SrcB;
  logic [2:0]  AluOp;
  logic [15:0] out;
  logic        Overflow;

  typedef struct packed {
    logic [15:0] res;
    logic        ovf;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  alu_unit #(.WIDTH(16)) dut (
    .clock(clock), .reset(reset),
    .mary(mary), .sp(sp), .shelley(shelley),
    .zext_imm(zext_imm), .sext_imm(sext_imm), .sext_ls_imm(sext_ls_imm),
    .SrcA(SrcA), .SrcB(SrcB), .AluOp(AluOp),
    .out(out), .Overflow(Overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step(input logic rst, input logic sa, input logic [1:0] sb,
                      input logic [2:0] op, input logic [15:0] eo, input logic ev,
                      input string tag);
    exp_t  e;
    string t;
    @(negedge clock);
    reset = rst; SrcA = sa; SrcB = sb; AluOp = op;
    sb_q.push_back('{res: eo, ovf: ev});
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
    n_checks++;
    assert (sb_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, got size %0d expected >0", tag, sb_q.size());
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      n_checks++;
      assert (out === e.res) else begin
        n_fail++;
        $error("FAIL %s.out: got %h expected %h", t, out, e.res);
      end
      n_checks++;
      assert (Overflow === e.ovf) else begin
        n_fail++;
        $error("FAIL %s.ovf: got %b expected %b", t, Overflow, e.ovf);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    mary = 16'd57; sp = 16'd62; shelley = 16'd75;
    zext_imm = 16'd80; sext_imm = 16'd34; sext_ls_imm = 16'd136;
    SrcA = 1'b0; SrcB = 2'b01; AluOp = OR_;
    @(posedge clock);
    step(1'b1, 1'b0, 2'b01, OR_, 16'd0, 1'b0, "reset");

    // logic
    step(1'b0, 1'b0, 2'b01, AND_, 16'd16,  1'b0, "and_zimm");
    step(1'b0, 1'b0, 2'b01, OR_,  16'd121, 1'b0, "or_zimm");
    step(1'b0, 1'b0, 2'b00, AND_, 16'd9,   1'b0, "and_reg");
    step(1'b0, 1'b0, 2'b00, OR_,  16'd123, 1'b0, "or_reg");
    // arithmetic
    step(1'b0, 1'b0, 2'b10, ADD_, 16'd91,    1'b0, "add_simm");
    step(1'b0, 1'b0, 2'b10, SUB_, 16'd23,    1'b0, "sub_simm");
    step(1'b0, 1'b0, 2'b00, ADD_, 16'd132,   1'b0, "add_reg");
    step(1'b0, 1'b0, 2'b00, SUB_, 16'hFFEE,  1'b0, "sub_reg_neg");
    // compares
    step(1'b0, 1'b0, 2'b10, SLT_, 16'd0, 1'b0, "slt_simm");
    step(1'b0, 1'b0, 2'b10, SGT_, 16'd1, 1'b0, "sgt_simm");
    step(1'b0, 1'b0, 2'b10, SEQ_, 16'd0, 1'b0, "seq_simm");
    step(1'b0, 1'b0, 2'b00, SLT_, 16'd1, 1'b0, "slt_reg");
    step(1'b0, 1'b0, 2'b00, SGT_, 16'd0, 1'b0, "sgt_reg");
    step(1'b0, 1'b0, 2'b00, SEQ_, 16'd0, 1'b0, "seq_reg");
    shelley = 16'd57;
    step(1'b0, 1'b0, 2'b00, SEQ_, 16'd1, 1'b0, "seq_equal");
    // source muxes
    step(1'b0, 1'b1, 2'b11, ADD_,   16'd198, 1'b0, "add_sp_lsimm");
    step(1'b0, 1'b1, 2'b01, PASSB_, 16'd80,  1'b0, "passb_zimm");
    step(1'b0, 1'b1, 2'b10, PASSB_, 16'd34,  1'b0, "passb_simm");
    // overflow and wrap
    mary = 16'h7FFF; shelley = 16'h0001;
    step(1'b0, 1'b0, 2'b00, ADD_, 16'h8000, 1'b1, "add_ovf");
    step(1'b0, 1'b0, 2'b00, OR_,  16'h7FFF, 1'b0, "or_no_ovf");
    mary = 16'h8000;
    step(1'b0, 1'b0, 2'b00, SUB_, 16'h7FFF, 1'b1, "sub_ovf");
    mary = 16'hFFFF;
    step(1'b0, 1'b0, 2'b00, ADD_, 16'h0000, 1'b0, "add_wrap");
    // signed compare where A-B overflows
    mary = 16'h7FFF; shelley = 16'h8000;
    step(1'b0, 1'b0, 2'b00, SLT_, 16'd0,    1'b0, "slt_edge");
    step(1'b0, 1'b0, 2'b00, SGT_, 16'd1,    1'b0, "sgt_edge");
    step(1'b0, 1'b0, 2'b00, SUB_, 16'hFFFF, 1'b1, "sub_edge_ovf");
    // mid-stream reset overrides an overflowing add, then resumes
    shelley = 16'h0001;
    step(1'b0, 1'b0, 2'b00, ADD_, 16'h8000, 1'b1, "pre_reset");
    step(1'b1, 1'b0, 2'b00, ADD_, 16'h0000, 1'b0, "reset_mid");
    step(1'b0, 1'b0, 2'b00, ADD_, 16'h8000, 1'b1, "resume");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
